// File: rtl/dmem_pkg.sv
// dmem_pkg: shared FSM states and sizing constants for the MEM-stage data responder.
package dmem_pkg;
    typedef enum logic [1:0] {IDLE, WAIT, ACCESS, RESP} state_t;
    localparam int WORD_BYTES = 4;
    localparam int STAT_W = 16;
endpackage

// File: rtl/dmem_if.sv
// dmem_if: request/response handshake between the MEM stage (master) and the data responder (slave).
interface dmem_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;
    modport master (
        output req_valid, req_write, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );
    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/dmem_array.sv
// dmem_array: DEPTH x 32 word storage, synchronous write and asynchronous read, contents not reset.
module dmem_array #(
    parameter int DEPTH = 256
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [31:0]              wdata,
    output logic [31:0]              rdata
);
    logic [31:0] mem [DEPTH];
    always_ff @(posedge clk)
        if (we) mem[addr] <= wdata;
    assign rdata = mem[addr];
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding load/store responder with WAIT_STATES access latency.
// Optional DMEM_STATS_EN adds saturating load/store response counters.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    dmem_if.slave             bus,
    output logic              busy
`ifdef DMEM_STATS_EN
    ,
    output logic [STAT_W-1:0] stat_loads,
    output logic [STAT_W-1:0] stat_stores
`endif
);
    localparam int AW  = $clog2(DEPTH);
    localparam int OFS = $clog2(WORD_BYTES);

    state_t      state;
    logic [3:0]  cnt;
    logic        wr_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] arr_rdata;
    logic        err;
    logic        we;

    // Out of range is any set bit above the word index, since DEPTH is a power of two.
    assign err = (addr_q[OFS-1:0] != '0) || (addr_q[31:AW+OFS] != '0);
    assign we  = (state == ACCESS) && wr_q && !err;

    dmem_array #(.DEPTH(DEPTH)) u_array (
        .clk   (clk),
        .we    (we),
        .addr  (addr_q[AW+OFS-1:OFS]),
        .wdata (wdata_q),
        .rdata (arr_rdata)
    );

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state          <= IDLE;
            cnt            <= '0;
            wr_q           <= 1'b0;
            addr_q         <= '0;
            wdata_q        <= '0;
            bus.req_ready  <= 1'b1;
            bus.resp_valid <= 1'b0;
            bus.resp_rdata <= '0;
            bus.resp_err   <= 1'b0;
            busy           <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.req_valid && bus.req_ready) begin
                    wr_q          <= bus.req_write;
                    addr_q        <= bus.req_addr;
                    wdata_q       <= bus.req_wdata;
                    cnt           <= 4'(WAIT_STATES);
                    state         <= (WAIT_STATES == 0) ? ACCESS : WAIT;
                    bus.req_ready <= 1'b0;
                    busy          <= 1'b1;
                end
                WAIT: begin
                    cnt   <= cnt - 4'd1;
                    state <= (cnt == 4'd1) ? ACCESS : WAIT;
                end
                ACCESS: begin
                    bus.resp_rdata <= (err || wr_q) ? '0 : arr_rdata;
                    bus.resp_err   <= err;
                    bus.resp_valid <= 1'b1;
                    state          <= RESP;
                end
                RESP: if (bus.resp_ready) begin
                    bus.resp_valid <= 1'b0;
                    bus.req_ready  <= 1'b1;
                    busy           <= 1'b0;
                    state          <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end

`ifdef DMEM_STATS_EN
    logic done;
    assign done = (state == RESP) && bus.resp_ready && !bus.resp_err;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            stat_loads  <= '0;
            stat_stores <= '0;
        end else begin
            if (done && !wr_q && stat_loads != '1) stat_loads <= stat_loads + 1'b1;
            if (done && wr_q && stat_stores != '1) stat_stores <= stat_stores + 1'b1;
        end
`endif
endmodule
